// File: rtl/instr_dispatch.sv
// Issue stage: stamps each accepted instruction with a sequential commit ID and
// parks it in a one-deep register per execution branch, throttled by an ID window.

module instr_dispatch_slot #(
    parameter int BLK_W = 8,
    parameter int OPS_W = 32,
    parameter int ID_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             ready,
    input  logic [BLK_W-1:0] in_block,
    input  logic [OPS_W-1:0] in_operands,
    input  logic [3:0]       in_dest,
    input  logic [ID_W-1:0]  in_id,
    input  logic             in_flag,
    output logic             valid,
    output logic [BLK_W-1:0] block,
    output logic [OPS_W-1:0] operands,
    output logic [3:0]       dest,
    output logic [ID_W-1:0]  commit_id,
    output logic             flag
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid     <= 1'b0;
            block     <= '0;
            operands  <= '0;
            dest      <= '0;
            commit_id <= '0;
            flag      <= 1'b0;
        end else if (enable) begin
            // a load wins over a same-cycle drain, keeping the slot full
            if (load) begin
                valid     <= 1'b1;
                block     <= in_block;
                operands  <= in_operands;
                dest      <= in_dest;
                commit_id <= in_id;
                flag      <= in_flag;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

module instr_dispatch #(
    parameter int data_width   = 16,
    parameter int n_blocks     = 256,
    parameter int n_branches   = 4,
    parameter int id_width     = 8,
    parameter int max_inflight = 8,
    localparam int BLK_W = $clog2(n_blocks),
    localparam int BR_W  = (n_branches > 1) ? $clog2(n_branches) : 1,
    localparam int OPS_W = 2 * data_width
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 sample_tick,
    input  logic                                 instr_valid,
    output logic                                 instr_ready,
    input  logic [BR_W-1:0]                      instr_branch,
    input  logic [BLK_W-1:0]                     instr_block,
    input  logic [OPS_W-1:0]                     instr_operands,
    input  logic [3:0]                           instr_dest,
    input  logic                                 instr_flag,
    output logic [n_branches-1:0]                out_valid,
    input  logic [n_branches-1:0]                out_ready,
    output logic [n_branches-1:0][BLK_W-1:0]     out_block,
    output logic [n_branches-1:0][OPS_W-1:0]     out_operands,
    output logic [n_branches-1:0][3:0]           out_dest,
    output logic [n_branches-1:0][id_width-1:0]  out_commit_id,
    output logic [n_branches-1:0]                out_flag,
    input  logic [id_width-1:0]                  next_commit_id,
    output logic [id_width-1:0]                  issue_id,
    output logic [id_width-1:0]                  inflight,
    output logic                                 bad_branch
);
    logic [n_branches-1:0] slot_free;
    logic [n_branches-1:0] load;
    logic                  branch_ok;
    logic                  sel_free;
    logic                  window_ok;
    logic                  accept;

    // modular difference keeps the window correct across ID wrap
    assign inflight  = issue_id - next_commit_id;
    assign window_ok = inflight < id_width'(max_inflight);
    assign slot_free = ~out_valid | out_ready;
    assign branch_ok = {1'b0, instr_branch} < (BR_W+1)'(n_branches);

    always_comb begin
        sel_free = 1'b0;
        if (branch_ok) sel_free = slot_free[instr_branch];
    end

    // out-of-range branches are always taken so they can be dropped
    assign instr_ready = enable & ~sample_tick & (~branch_ok | (sel_free & window_ok));
    assign accept      = instr_valid & instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_id   <= '0;
            bad_branch <= 1'b0;
        end else if (accept) begin
            if (branch_ok) issue_id   <= issue_id + 1'b1;
            else           bad_branch <= 1'b1;
        end
    end

    for (genvar b = 0; b < n_branches; b++) begin : g_slot
        assign load[b] = accept & branch_ok & (instr_branch == BR_W'(b));

        instr_dispatch_slot #(.BLK_W(BLK_W), .OPS_W(OPS_W), .ID_W(id_width)) u_slot (
            .clk         (clk),
            .reset       (reset),
            .enable      (enable),
            .load        (load[b]),
            .ready       (out_ready[b]),
            .in_block    (instr_block),
            .in_operands (instr_operands),
            .in_dest     (instr_dest),
            .in_id       (issue_id),
            .in_flag     (instr_flag),
            .valid       (out_valid[b]),
            .block       (out_block[b]),
            .operands    (out_operands[b]),
            .dest        (out_dest[b]),
            .commit_id   (out_commit_id[b]),
            .flag        (out_flag[b])
        );
    end
endmodule
